// File: rtl/run_ctrl.sv
// Run sequencer for the 3BC processor: start/stop handshake, PC/commit gating,
// optional memory stall cycle, and cycle/instruction/watchdog counters.
module run_ctrl #(
    parameter int CW         = 16,
    parameter int MAX_CYCLES = 50000,
    parameter bit MEM_STALL  = 1'b1
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          HaltReq,
    input  logic          MemOp,
    output logic          PcEn,
    output logic          PgmRst,
    output logic          CommitEn,
    output logic          Ack,
    output logic          Timeout,
    output logic [CW-1:0] CycleCt,
    output logic [CW-1:0] InstCt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_RUN,
        S_MEM,
        S_DONE
    } state_t;

    localparam logic [CW-1:0] CT_MAX  = '1;
    localparam logic [CW-1:0] WD_LAST = CW'(MAX_CYCLES - 1);

    state_t        r_state;
    logic [CW-1:0] r_cycle_ct;
    logic [CW-1:0] r_inst_ct;
    logic          r_timeout;
    logic          r_pgm_rst;
    logic          r_ack;

    logic w_active;
    logic w_halt;
    logic w_stall;
    logic w_wd;
    logic w_advance;

    assign w_active  = (r_state == S_RUN) || (r_state == S_MEM);
    // Halt and stall are decoded only in RUN; in MEM the held instruction is finishing.
    assign w_halt    = (r_state == S_RUN) && HaltReq;
    assign w_stall   = (r_state == S_RUN) && MemOp && MEM_STALL;
    assign w_wd      = w_active && (r_cycle_ct == WD_LAST);
    assign w_advance = w_active && !Reset && !Start && !w_halt && !w_wd && !w_stall;

    assign PcEn     = w_advance;
    assign CommitEn = w_advance;
    assign PgmRst   = r_pgm_rst;
    assign Ack      = r_ack;
    assign Timeout  = r_timeout;
    assign CycleCt  = r_cycle_ct;
    assign InstCt   = r_inst_ct;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CT_MAX) ? v : v + CW'(1);
    endfunction

    // NOTE: all state updates use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= S_IDLE;
            r_cycle_ct <= '0;
            r_inst_ct  <= '0;
            r_timeout  <= 1'b0;
            r_pgm_rst  <= 1'b0;
            r_ack      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_state   <= S_ARMED;
                        r_pgm_rst <= 1'b1;
                    end
                end
                S_ARMED: begin
                    if (!Start) begin
                        r_state    <= S_RUN;
                        r_pgm_rst  <= 1'b0;
                        r_cycle_ct <= '0;
                        r_inst_ct  <= '0;
                        r_timeout  <= 1'b0;
                    end
                end
                S_RUN, S_MEM: begin
                    if (Start) begin
                        r_state   <= S_ARMED;
                        r_pgm_rst <= 1'b1;
                    end else if (w_halt) begin
                        r_state    <= S_DONE;
                        r_ack      <= 1'b1;
                        r_cycle_ct <= sat_inc(r_cycle_ct);
                        r_inst_ct  <= sat_inc(r_inst_ct);
                    end else if (w_wd) begin
                        r_state   <= S_DONE;
                        r_ack     <= 1'b1;
                        r_timeout <= 1'b1;
                    end else if (w_stall) begin
                        r_state    <= S_MEM;
                        r_cycle_ct <= sat_inc(r_cycle_ct);
                    end else begin
                        r_state    <= S_RUN;
                        r_cycle_ct <= sat_inc(r_cycle_ct);
                        r_inst_ct  <= sat_inc(r_inst_ct);
                    end
                end
                S_DONE: begin
                    if (Start) begin
                        r_state   <= S_ARMED;
                        r_ack     <= 1'b0;
                        r_pgm_rst <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_pgm_rst <= 1'b0;
                    r_ack     <= 1'b0;
                end
            endcase
        end
    end

endmodule
